// File: rtl/alu_shared_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands are registered and held for a per-opcode cycle count before the result is sampled.
module alu_shared_sequencer #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryFlag,
  input  logic             alu_zeroFlag,
  input  logic             alu_signFlag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic             busy
);

  localparam int unsigned CW = (DIV_CYCLES < 2) ? 1 : $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES);
  localparam logic [3:0]    OP_SUB  = 4'd1;
  localparam logic [3:0]    OP_DIV  = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state, w_next;
  logic             r_last_grant;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_rsp_result;
  logic [4:0]       r_alu_sh;
  logic             r_rsp_id, r_rsp_carry, r_rsp_zero, r_rsp_sign;

  logic             w_grant0, w_grant1, w_accept, w_done;
  logic [3:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a, w_sel_b;
  logic [4:0]       w_sel_sh;

  // On contention the requester that did not win last time is granted.
  assign w_grant0 = (r_state == S_IDLE) && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = (r_state == S_IDLE) && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept = w_grant0 || w_grant1;
  assign w_done   = (r_state == S_EXEC) && (r_cnt <= CNT_ONE);

  assign w_sel_op = w_grant1 ? req1_opcode : req0_opcode;
  assign w_sel_a  = w_grant1 ? req1_a      : req0_a;
  assign w_sel_b  = w_grant1 ? req1_b      : req0_b;
  assign w_sel_sh = w_grant1 ? req1_shamt  : req0_shamt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  if (w_done) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sh     <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_sign   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_op     <= w_sel_op;
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_sh     <= w_sel_sh;
        r_rsp_id     <= w_grant1;
        r_last_grant <= w_grant1;
        r_cnt        <= (w_sel_op == OP_DIV) ? CNT_DIV : CNT_ONE;
      end
      if (r_state == S_EXEC) begin
        if (w_done) begin
          r_cnt        <= '0;
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zeroFlag;
          r_rsp_sign   <= alu_signFlag;
          r_rsp_carry  <= (r_alu_op <= OP_SUB) ? alu_carryFlag : 1'b0;
        end else begin
          r_cnt <= r_cnt - CNT_ONE;
        end
      end
    end
  end

  assign req0_ready     = w_grant0;
  assign req1_ready     = w_grant1;
  assign alu_opcode     = r_alu_op;
  assign alu_input1     = r_alu_a;
  assign alu_input2     = r_alu_b;
  assign alu_shiftValue = r_alu_sh;
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_id         = r_rsp_id;
  assign rsp_result     = r_rsp_result;
  assign rsp_carry      = r_rsp_carry;
  assign rsp_zero       = r_rsp_zero;
  assign rsp_sign       = r_rsp_sign;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_shared_sequencer.sv
// Bench for alu_shared_sequencer: stub ALU, transaction-level timing model checked every cycle,
// plus directed transactions with hand-computed results and latencies.
module tb_alu_shared_sequencer;

  localparam int unsigned W  = 64;
  localparam int unsigned DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_opcode, req1_opcode, alu_opcode;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_shamt, req1_shamt, alu_shiftValue;
  logic [W-1:0] alu_input1, alu_input2, alu_result, rsp_result;
  logic         alu_carryFlag, alu_zeroFlag, alu_signFlag;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_sign, busy;
  logic         force_carry;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  alu_shared_sequencer #(.WIDTH(W), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag), .alu_signFlag(alu_signFlag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         s;
  } res_t;

  function automatic res_t alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] sh, input logic fc);
    logic [W:0] t;
    res_t o;
    t = '0;
    case (op)
      4'd0: t = {1'b0, a} + {1'b0, b};
      4'd1: t = {1'b0, a} + {1'b0, ~b} + 65'd1;
      4'd2: t = {1'b0, a & b};
      4'd3: t = {1'b0, a | b};
      4'd4: t = {1'b0, a << sh};
      4'd5: t = {1'b0, ~(a ^ b)};
      4'd6: t = {1'b0, b};
      4'd7: t = (b == '0) ? '0 : {1'b0, a / b};
      default: t = {1'b0, a ^ b};
    endcase
    o.r = t[W-1:0];
    o.c = t[W] | fc;
    o.z = (o.r == '0);
    o.s = o.r[W-1];
    return o;
  endfunction

  // Stub ALU, purely combinational on the sequencer's registered operands.
  res_t alu_out;
  always_comb begin
    alu_out       = alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue, force_carry);
    alu_result    = alu_out.r;
    alu_carryFlag = alu_out.c;
    alu_zeroFlag  = alu_out.z;
    alu_signFlag  = alu_out.s;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Transaction model: one op in flight, response due at accept+1+k, held until handshake.
  logic         m_inflight, m_last, m_id;
  int           m_due;
  logic [3:0]   m_op;
  logic [W-1:0] m_a, m_b;
  logic [4:0]   m_sh;
  res_t         m_rsp, m_pend;
  logic         p_rst = 1'b1, p_acc = 1'b0, p_hs = 1'b0, p_id = 1'b0;
  logic [3:0]   p_op;
  logic [W-1:0] p_a, p_b;
  logic [4:0]   p_sh;
  int           p_due;
  res_t         p_pend;

  initial forever begin
    logic e_valid, e_g0, e_g1;
    res_t r;
    @(negedge clk);
    if (p_rst) begin
      m_inflight = 1'b0; m_last = 1'b1; m_id = 1'b0; m_due = 0;
      m_op = '0; m_a = '0; m_b = '0; m_sh = '0; m_rsp = '0; m_pend = '0;
    end else begin
      if (p_hs) m_inflight = 1'b0;
      if (p_acc) begin
        m_inflight = 1'b1; m_due = p_due; m_last = p_id; m_id = p_id;
        m_op = p_op; m_a = p_a; m_b = p_b; m_sh = p_sh; m_pend = p_pend;
      end
      if (m_inflight && cyc == m_due) m_rsp = m_pend;
    end
    e_valid = m_inflight && (cyc >= m_due);
    e_g0 = !m_inflight && req0_valid && (!req1_valid || m_last);
    e_g1 = !m_inflight && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", 64'(req0_ready), 64'(e_g0));
    chk("req1_ready", 64'(req1_ready), 64'(e_g1));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    chk("busy", 64'(busy), 64'(m_inflight));
    chk("alu_opcode", 64'(alu_opcode), 64'(m_op));
    chk("alu_input1", alu_input1, m_a);
    chk("alu_input2", alu_input2, m_b);
    chk("alu_shift", 64'(alu_shiftValue), 64'(m_sh));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_result", rsp_result, m_rsp.r);
    chk("rsp_carry", 64'(rsp_carry), 64'(m_rsp.c));
    chk("rsp_zero", 64'(rsp_zero), 64'(m_rsp.z));
    chk("rsp_sign", 64'(rsp_sign), 64'(m_rsp.s));
    p_rst = rst;
    p_acc = e_g0 || e_g1;
    p_id  = e_g1;
    p_op  = e_g1 ? req1_opcode : req0_opcode;
    p_a   = e_g1 ? req1_a : req0_a;
    p_b   = e_g1 ? req1_b : req0_b;
    p_sh  = e_g1 ? req1_shamt : req0_shamt;
    p_due = cyc + 1 + ((p_op == 4'd7) ? int'(DC) : 1);
    r = alu_fn(p_op, p_a, p_b, p_sh, force_carry);
    if (p_op > 4'd1) r.c = 1'b0;
    p_pend = r;
    p_hs  = e_valid && rsp_ready;
  end

  task automatic drive(input int port, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh);
    if (port == 0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; req0_shamt = sh;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; req1_shamt = sh;
    end
  endtask

  // Returns at #1 after the accept edge with the accept cycle; caller drops valid.
  task automatic wait_accept(input int port, output int c);
    bit found = 0;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        c = cyc; found = 1;
        break;
      end
    end
    nchk++;
    if (!found) begin
      nerr++;
      $display("FAIL accept_timeout port=%0d actual=no_ready required=ready", port);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input string name, input int exp_cyc, input logic [W-1:0] r,
                          input logic id, input logic c, input logic z, input logic s);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1; break; end
    end
    chk({name, "_seen"}, 64'(found), 64'd1);
    chk({name, "_lat"}, 64'(cyc), 64'(exp_cyc));
    chk({name, "_res"}, rsp_result, r);
    chk({name, "_id"}, 64'(rsp_id), 64'(id));
    chk({name, "_c"}, 64'(rsp_carry), 64'(c));
    chk({name, "_z"}, 64'(rsp_zero), 64'(z));
    chk({name, "_s"}, 64'(rsp_sign), 64'(s));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    nerr++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    int c, h;
    rst = 1'b1; rsp_ready = 1'b1; force_carry = 1'b0;
    req0_valid = 0; req0_opcode = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
    req1_valid = 0; req1_opcode = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_alu_a", alu_input1, 64'd0);
    chk("reset_result", rsp_result, 64'd0);
    @(posedge clk); #1;

    drive(0, 4'd0, 64'd5, 64'd7, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    wait_rsp("add", c + 2, 64'd12, 0, 0, 0, 0);

    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    drive(0, 4'd1, 64'd3, 64'd3, 5'd0);
    drive(1, 4'd3, 64'hF0, 64'h0F, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    wait_rsp("sub", c + 2, 64'd0, 0, 1, 1, 0);
    wait_accept(1, c); req1_valid = 0;
    wait_rsp("or", c + 2, 64'hFF, 1, 0, 0, 0);
    drive(0, 4'd0, 64'd1, 64'd2, 5'd0);
    drive(1, 4'd6, 64'd0, 64'd9, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    wait_rsp("cont0", c + 2, 64'd3, 0, 0, 0, 0);
    wait_accept(1, c); req1_valid = 0;
    wait_rsp("cont1", c + 2, 64'd9, 1, 0, 0, 0);

    drive(0, 4'd7, 64'd100, 64'd7, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    wait_rsp("div", c + 1 + int'(DC), 64'd14, 0, 0, 0, 0);
    drive(1, 4'd7, 64'd7, 64'd0, 5'd0);
    wait_accept(1, c); req1_valid = 0;
    wait_rsp("div0", c + 1 + int'(DC), 64'd0, 1, 0, 1, 0);

    drive(1, 4'd5, 64'd0, 64'd0, 5'd0);
    drive(0, 4'd4, 64'd1, 64'd0, 5'd4);
    wait_accept(0, c); req0_valid = 0; rsp_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("bp_lat", 64'(cyc), 64'(c + 2));
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_res", rsp_result, 64'd16);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 64'(rsp_valid), 64'd1);
    h = cyc;
    @(negedge clk);
    chk("bp_req1_accept", 64'(req1_ready), 64'd1);
    chk("bp_req1_cycle", 64'(cyc), 64'(h + 1));
    c = cyc;
    @(posedge clk); #1 req1_valid = 0;
    wait_rsp("xnor", c + 2, '1, 1, 0, 0, 1);

    drive(0, 4'd7, 64'd50, 64'd5, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_op", 64'(alu_opcode), 64'd0);
    chk("rst_alu_a", alu_input1, 64'd0);
    chk("rst_alu_b", alu_input2, 64'd0);
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    drive(1, 4'd0, 64'd2, 64'd2, 5'd0);
    wait_accept(1, c); req1_valid = 0;
    wait_rsp("post_rst", c + 2, 64'd4, 1, 0, 0, 0);

    force_carry = 1'b1;
    drive(0, 4'd2, 64'hF0, 64'hFF, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    wait_rsp("and_fc", c + 2, 64'hF0, 0, 0, 0, 0);
    drive(0, 4'd0, '1, 64'd1, 5'd0);
    wait_accept(0, c); req0_valid = 0;
    wait_rsp("add_ovf", c + 2, 64'd0, 0, 1, 1, 0);
    force_carry = 1'b0;

    drive(1, 4'd12, 64'd3, 64'd5, 5'd0);
    wait_accept(1, c); req1_valid = 0;
    wait_rsp("op12", c + 2, 64'd6, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_shared_sequencer.md
# alu_shared_sequencer

- Two-port round-robin sequencer that shares one combinational 64-bit ALU between two requesters.
- Registers the winning request's operands onto the ALU inputs and holds them stable for a per-opcode number of cycles; DIV is a multicycle path of DIV_CYCLES cycles.
- Samples result and flags into a response register with a valid/ready handshake.
- Sits between issuing engines and the generated ALU instance.

## Interface
- WIDTH, 64, operand/result width
- DIV_CYCLES, 4, cycles operands are held before sampling a DIV result (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  requester N (N=0,1) has an operation
- reqN_ready  out  1  requester N accepted this cycle
- reqN_opcode  in  4  ALU opcode: ADD=0, SUB=1, AND=2, OR=3, SLL=4, XNOR=5, PASSB=6, DIV=7
- reqN_a, reqN_b  in  WIDTH  operands
- reqN_shamt  in  5  shift amount
- alu_opcode  out  4  to ALU
- alu_input1, alu_input2  out  WIDTH  to ALU
- alu_shiftValue  out  5  to ALU
- alu_result  in  WIDTH  from ALU
- alu_carryFlag, alu_zeroFlag, alu_signFlag  in  1  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_result  out  WIDTH  sampled result
- rsp_carry, rsp_zero, rsp_sign  out  1  sampled flags
- busy  out  1  state ≠ IDLE

## Operation
States: IDLE, EXEC, RESP.

**IDLE**
- Grant among valid requesters; if both are valid, grant the one ≠ last_grant.
- reqN_ready is asserted combinationally for the granted requester only, never both.
- On accept:
  - Register opcode, a, b and shamt onto the alu_* outputs.
  - Store rsp_id and update last_grant.
  - Load cnt = DIV_CYCLES if opcode == 7, else 1.
  - Go to EXEC.

**EXEC**
- alu_* outputs are frozen.
- While cnt > 1, decrement cnt each cycle.
- When cnt == 1, on that edge:
  - Capture alu_result into rsp_result.
  - Capture alu_zeroFlag and alu_signFlag into rsp_zero and rsp_sign.
  - Set rsp_carry = alu_carryFlag for opcode 0/1, else 0.
  - Go to RESP.

**RESP**
- rsp_valid = 1 and all rsp_* fields are stable.
- On rsp_valid & rsp_ready, go to IDLE.
- No request is accepted in RESP or EXEC.

**Other rules**
- Opcodes 8–15 are not rejected: they use cnt = 1, and the ALU's output is forwarded as-is.
- alu_* outputs keep their last values in IDLE and RESP; they change only on accept.
- Requesters must hold their payload stable while valid && !ready; the sequencer captures only on the accept edge.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention), cnt = 0.
  - All alu_* and rsp_* outputs = 0; rsp_valid = 0; busy = 0; both reqN_ready = 0 unless granted in IDLE.
- Let C be the accept cycle (valid & ready high).
  - EXEC occupies cycles C+1 … C+k, where k = 1 for non-DIV and DIV_CYCLES for DIV.
  - rsp_valid first rises in cycle C+1+k.
- If rsp_ready is high in the first RESP cycle, the response handshakes in that cycle. The next accept happens no earlier than the following cycle (IDLE), so minimum issue spacing is k+2 cycles.
- Back-pressure: rsp_valid and rsp_* hold indefinitely until rsp_ready.
- rst mid-operation, in any state:
  - Everything returns to reset values on the next edge.
  - The in-flight operation is dropped; no response is produced.
- A requester deasserting valid in IDLE before being granted is legal; nothing is captured.
- DIV_CYCLES = 1: DIV timing is identical to the other opcodes.
- Fairness: under continuous dual requests, grants strictly alternate 0, 1, 0, 1, …

## Test plan
- Single ADD from req0 (a=5, b=7, rsp_ready=1) → rsp_valid in cycle C+2, rsp_result=12, rsp_id=0, rsp_zero=0, rsp_sign=0.
- Both requesters valid from reset, req0 SUB(3,3), req1 OR(0xF0,0x0F) → req0 granted first with rsp_zero=1; then req1 with rsp_result=0xFF, rsp_id=1; a later contention grants req0 again.
- DIV 100/7 with DIV_CYCLES=4 → alu_* stable for cycles C+1…C+4, rsp_valid in C+5, rsp_result=14; DIV by 0 → rsp_result=0, rsp_zero=1.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid while req1 stays valid → rsp_* unchanged, req1_ready=0 throughout, req1 accepted the cycle after the handshake.
- rst asserted in the 2nd EXEC cycle of a DIV → next cycle IDLE, all outputs 0, no rsp_valid ever for that op; the next request completes normally.
- AND with alu_carryFlag forced 1 → rsp_carry=0; ADD of all-ones + 1 with alu_carryFlag=1 → rsp_carry=1, rsp_zero=1.
